button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 151 +++++++++++++++
 tb/tb_button_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, debounce FSM,
// one-cycle press/release pulses and a saturating long-press flag.
// Raw buttons are active-low; every output is active-high.
module button_conditioner #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned STABLE_CNT = 40,
    parameter int unsigned HOLD_CNT   = 4000
) (
    input  logic             clk_2K,
    input  logic             i_Reset_n,
    input  logic [N_BTN-1:0] i_BtnRaw,
    output logic [N_BTN-1:0] o_BtnDeb,
    output logic [N_BTN-1:0] o_BtnPress,
    output logic [N_BTN-1:0] o_BtnRelease,
    output logic [N_BTN-1:0] o_BtnLong
);

    localparam int unsigned DEB_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CNT + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(STABLE_CNT - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CNT);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_s;

    // Invert to active-high and resynchronize the raw buttons into clk_2K.
    always_ff @(posedge clk_2K or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= ~i_BtnRaw;
            sync_s    <= sync_meta;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        state_t              state;
        state_t              state_nxt;
        logic [DEB_W-1:0]    deb_cnt;
        logic [DEB_W-1:0]    deb_cnt_nxt;
        logic [HOLD_W-1:0]   hold_cnt;
        logic [HOLD_W-1:0]   hold_cnt_nxt;
        logic                deb;
        logic                deb_nxt;
        logic                press;
        logic                press_nxt;
        logic                rel_pulse;
        logic                rel_pulse_nxt;

        // Debounce decisions: a level change is accepted only after
        // STABLE_CNT consecutive agreeing synchronized samples.
        always_comb begin
            state_nxt     = state;
            deb_cnt_nxt   = deb_cnt;
            press_nxt     = 1'b0;
            rel_pulse_nxt = 1'b0;
            case (state)
                RELEASED: begin
                    if (sync_s[g]) begin
                        state_nxt   = PRESS_PEND;
                        deb_cnt_nxt = DEB_ONE;
                    end else begin
                        deb_cnt_nxt = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!sync_s[g]) begin
                        state_nxt   = RELEASED;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt   = PRESSED;
                        deb_cnt_nxt = '0;
                        press_nxt   = 1'b1;
                    end else begin
                        deb_cnt_nxt = deb_cnt + DEB_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_s[g]) begin
                        state_nxt   = REL_PEND;
                        deb_cnt_nxt = DEB_ONE;
                    end
                end
                REL_PEND: begin
                    if (sync_s[g]) begin
                        state_nxt   = PRESSED;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt     = RELEASED;
                        deb_cnt_nxt   = '0;
                        rel_pulse_nxt = 1'b1;
                    end else begin
                        deb_cnt_nxt = deb_cnt + DEB_ONE;
                    end
                end
                default: begin
                    state_nxt   = RELEASED;
                    deb_cnt_nxt = '0;
                end
            endcase

            deb_nxt = (state_nxt == PRESSED) || (state_nxt == REL_PEND);

            // Hold time restarts only on a freshly accepted press; a rejected
            // release (REL_PEND back to PRESSED) keeps accumulating.
            if ((state == PRESS_PEND) && (state_nxt == PRESSED)) begin
                hold_cnt_nxt = '0;
            end else if (deb && (hold_cnt != HOLD_MAX)) begin
                hold_cnt_nxt = hold_cnt + HOLD_ONE;
            end else begin
                hold_cnt_nxt = hold_cnt;
            end
        end

        // Channel state, counters and registered outputs.
        always_ff @(posedge clk_2K or negedge i_Reset_n) begin
            if (!i_Reset_n) begin
                state     <= RELEASED;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                deb       <= 1'b0;
                press     <= 1'b0;
                rel_pulse <= 1'b0;
            end else begin
                state     <= state_nxt;
                deb_cnt   <= deb_cnt_nxt;
                hold_cnt  <= hold_cnt_nxt;
                deb       <= deb_nxt;
                press     <= press_nxt;
                rel_pulse <= rel_pulse_nxt;
            end
        end

        assign o_BtnDeb[g]     = deb;
        assign o_BtnPress[g]   = press;
        assign o_BtnRelease[g] = rel_pulse;
        assign o_BtnLong[g]    = deb && (hold_cnt == HOLD_MAX);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a sliding-window behavioural model checked
// every cycle, plus directed latency/pulse expectations.
module tb_button_conditioner;

    localparam int unsigned N      = 4;
    localparam int unsigned STABLE = 40;
    localparam int unsigned HOLD   = 4000;

    logic         clk_2K    = 1'b0;
    logic         i_Reset_n = 1'b0;
    logic [N-1:0] i_BtnRaw  = '1;
    logic [N-1:0] o_BtnDeb;
    logic [N-1:0] o_BtnPress;
    logic [N-1:0] o_BtnRelease;
    logic [N-1:0] o_BtnLong;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned tb_cyc = 0;

    button_conditioner #(
        .N_BTN      (N),
        .STABLE_CNT (STABLE),
        .HOLD_CNT   (HOLD)
    ) dut (
        .clk_2K       (clk_2K),
        .i_Reset_n    (i_Reset_n),
        .i_BtnRaw     (i_BtnRaw),
        .o_BtnDeb     (o_BtnDeb),
        .o_BtnPress   (o_BtnPress),
        .o_BtnRelease (o_BtnRelease),
        .o_BtnLong    (o_BtnLong)
    );

    always #5 clk_2K = ~clk_2K;

    always @(posedge clk_2K) tb_cyc++;

    // Reference: the debounced level flips once the last STABLE synchronized
    // samples all disagree with it; long = pressed for at least HOLD cycles.
    logic [STABLE-1:0] m_hist [N];
    logic [N-1:0]      m_s1, m_s2, m_deb, m_press, m_rel, m_long;
    int unsigned       m_cyc = 0;
    int unsigned       m_rise [N];

    always @(posedge clk_2K or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < N; i++) m_hist[i] = '0;
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_press = '0; m_rel = '0; m_long = '0;
        end else begin
            m_cyc++;
            for (int i = 0; i < N; i++) begin
                m_hist[i]  = {m_hist[i][STABLE-2:0], m_s2[i]};
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (!m_deb[i] && (m_hist[i] == {STABLE{1'b1}})) begin
                    m_deb[i] = 1'b1; m_press[i] = 1'b1; m_rise[i] = m_cyc;
                end else if (m_deb[i] && (m_hist[i] == {STABLE{1'b0}})) begin
                    m_deb[i] = 1'b0; m_rel[i] = 1'b1;
                end
                m_long[i] = m_deb[i] && ((m_cyc - m_rise[i]) >= HOLD);
            end
            m_s2 = m_s1;
            m_s1 = ~i_BtnRaw;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk_2K) begin
        logic [4*N-1:0] got, exp;
        got = {o_BtnDeb, o_BtnPress, o_BtnRelease, o_BtnLong};
        exp = {m_deb, m_press, m_rel, m_long};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got deb/press/rel/long=%h, expected %h",
                     $time, got, exp);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // kind 0 watches o_BtnDeb, kind 1 watches o_BtnLong; returns -1 on timeout.
    task automatic wait_sig(input int kind, input int ch, input logic val,
                            input int limit, output int n);
        logic v;
        n = 0;
        do begin
            @(posedge clk_2K); #1;
            n++;
            v = (kind == 0) ? o_BtnDeb[ch] : o_BtnLong[ch];
        end while (v !== val && n < limit);
        if (v !== val) n = -1;
    endtask

    initial begin
        int          n;
        int unsigned t_rise;
        logic        seen;
        int          rem [N];
        int          r;

        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        int unsigned t_rise;
        logic        seen;
        int          rem [N];
        int unsigned r;

        // Reset state
        repeat (3) @(negedge clk_2K);
        check("reset_outputs", int'({o_BtnDeb, o_BtnPress, o_BtnRelease, o_BtnLong}), 0);
        #2 i_Reset_n = 1'b1;
        repeat (5) @(negedge clk_2K);

        // Single press/release latency on bit 0
        i_BtnRaw[0] = 1'b0;
        wait_sig(0, 0, 1'b1, 200, n);
        check("press_latency_b0", n, 42);
        check("press_pulse_b0", int'(o_BtnPress), 1);
        check("deb_only_b0", int'(o_BtnDeb), 1);
        @(posedge clk_2K); #1;
        check("press_one_cycle_b0", int'(o_BtnPress), 0);
        @(negedge clk_2K) i_BtnRaw[0] = 1'b1;
        wait_sig(0, 0, 1'b0, 200, n);
        check("release_latency_b0", n, 42);
        check("release_pulse_b0", int'(o_BtnRelease), 1);
        @(posedge clk_2K); #1;
        check("release_one_cycle_b0", int'(o_BtnRelease), 0);

        // 39-cycle bounces on bit 1 must be rejected
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk_2K) i_BtnRaw[1] = 1'b0;
            repeat (39) begin
                @(negedge clk_2K);
                seen |= o_BtnDeb[1] | o_BtnPress[1];
            end
            i_BtnRaw[1] = 1'b1;
            repeat (10) begin
                @(negedge clk_2K);
                seen |= o_BtnDeb[1] | o_BtnPress[1];
            end
        end
        repeat (45) begin
            @(negedge clk_2K);
            seen |= o_BtnDeb[1] | o_BtnPress[1];
        end
        check("bounce_rejected_b1", int'(seen), 0);

        // Long press on bit 2, held 4100 cycles
        @(negedge clk_2K) i_BtnRaw[2] = 1'b0;
        wait_sig(0, 2, 1'b1, 200, n);
        check("press_latency_b2", n, 42);
        t_rise = tb_cyc;
        wait_sig(1, 2, 1'b1, 5000, n);
        check("long_delay_b2", int'(tb_cyc - t_rise), 4000);
        repeat (58) @(negedge clk_2K);
        i_BtnRaw[2] = 1'b1;
        wait_sig(1, 2, 1'b0, 200, n);
        check("long_fall_latency_b2", n, 42);
        check("release_pulse_b2", int'(o_BtnRelease), 4);
        check("deb_clear_b2", int'(o_BtnDeb[2]), 0);

        // 20-cycle glitch while pressed on bit 3
        @(negedge clk_2K) i_BtnRaw[3] = 1'b0;
        wait_sig(0, 3, 1'b1, 200, n);
        check("press_latency_b3", n, 42);
        t_rise = tb_cyc;
        repeat (100) @(negedge clk_2K);
        i_BtnRaw[3] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk_2K);
            seen |= ~o_BtnDeb[3] | o_BtnRelease[3];
        end
        i_BtnRaw[3] = 1'b0;
        repeat (60) begin
            @(negedge clk_2K);
            seen |= ~o_BtnDeb[3] | o_BtnRelease[3];
        end
        check("glitch_ignored_b3", int'(seen), 0);
        wait_sig(1, 3, 1'b1, 5000, n);
        check("long_delay_b3", int'(tb_cyc - t_rise), 4000);
        @(negedge clk_2K) i_BtnRaw[3] = 1'b1;
        wait_sig(0, 3, 1'b0, 200, n);
        check("release_latency_b3", n, 42);

        // Reset in the middle of a pending press, buttons held through it
        @(negedge clk_2K) i_BtnRaw[2] = 1'b0;
        wait_sig(0, 2, 1'b1, 200, n);
        check("press_latency_b2_again", n, 42);
        @(negedge clk_2K) i_BtnRaw[0] = 1'b0;
        repeat (32) @(posedge clk_2K);
        #3;
        check("deb2_before_reset", int'(o_BtnDeb[2]), 1);
        i_Reset_n = 1'b0;
        #1;
        check("reset_clears_outputs", int'({o_BtnDeb, o_BtnPress, o_BtnRelease, o_BtnLong}), 0);
        repeat (3) @(negedge clk_2K);
        #2 i_Reset_n = 1'b1;
        wait_sig(0, 0, 1'b1, 200, n);
        check("press_after_reset", n, 42);
        check("press_pulse_after_reset", int'(o_BtnPress), 5);
        @(negedge clk_2K) i_BtnRaw = '1;
        repeat (60) @(negedge clk_2K);

        // Simultaneous press on bits 0 and 3
        i_BtnRaw[0] = 1'b0;
        i_BtnRaw[3] = 1'b0;
        wait_sig(0, 0, 1'b1, 200, n);
        check("simul_press_latency", n, 42);
        check("simul_press_pulse", int'(o_BtnPress), 9);
        @(negedge clk_2K) i_BtnRaw = '1;
        repeat (60) @(negedge clk_2K);

        // Randomized bouncing around the acceptance threshold
        for (int i = 0; i < N; i++) rem[i] = int'($urandom_range(1, 50));
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_2K);
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    i_BtnRaw[i] = ~i_BtnRaw[i];
                    r = $urandom_range(0, 9);
                    rem[i] = (r < 3) ? int'($urandom_range(1, 12))
                                     : int'($urandom_range(37, 43));
                end else begin
                    rem[i]--;
                end
            end
            if (c == 1500 || c == 3000) begin
                #($urandom_range(6, 9));
                i_Reset_n = 1'b0;
            end
            if (c == 1503 || c == 3003) begin
                #2 i_Reset_n = 1'b1;
            end
        end
        i_BtnRaw = '1;
        repeat (60) @(negedge clk_2K);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
